baud_controller_rx_param: RTL

BAUD_CONTROLLER_RX_PARAM -- requirements
Module: baud_controller_rx_param

---
 rtl/baud_controller_rx_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/baud_controller_rx_param.sv
// Receive-side baud controller: a fractional phase accumulator produces
// oversample ticks, a tick index locates the bit centre, and three samples
// taken around that centre are majority-voted into one received bit.
module baud_controller_rx_param #(
  parameter int ACC_W        = 24,
  parameter int OVERSAMPLE   = 16,
  parameter int SAMPLE_POINT = OVERSAMPLE / 2,
  localparam int IDX_W       = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [ACC_W-1:0] incr,
  input  logic             align,
  input  logic             rx_in,
  output logic             os_tick,
  output logic [IDX_W-1:0] os_idx,
  output logic             sample_enable,
  output logic             bit_tick,
  output logic             bit_valid,
  output logic             bit_value
);

  // Tick indices of interest within one bit period.
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_PRE   = IDX_W'(SAMPLE_POINT - 1);
  localparam logic [IDX_W-1:0] IDX_MID   = IDX_W'(SAMPLE_POINT);
  localparam logic [IDX_W-1:0] IDX_POST  = IDX_W'(SAMPLE_POINT + 1);

  // Phase accumulator and tick position.
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [IDX_W-1:0] idx_reg, idx_next, idx_inc;

  // Early and centre samples held until the third sample arrives.
  logic             vote0_reg, vote0_next;
  logic             vote1_reg, vote1_next;

  // Registered outputs.
  logic             tick_reg, tick_next;
  logic             se_reg, se_next;
  logic             bt_reg, bt_next;
  logic             bv_reg, bv_next;
  logic             val_reg, val_next;

  // Next-state logic: align beats enable, enable gates all phase advance.
  always_comb begin
    sum        = {1'b0, acc_reg} + {1'b0, incr};
    carry      = sum[ACC_W];
    idx_inc    = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

    acc_next   = acc_reg;
    idx_next   = idx_reg;
    vote0_next = vote0_reg;
    vote1_next = vote1_reg;
    tick_next  = 1'b0;
    se_next    = 1'b0;
    bt_next    = 1'b0;
    bv_next    = 1'b0;
    val_next   = val_reg;

    if (align) begin
      // Restart the bit so the next tick is index 0; the partial bit is lost.
      acc_next   = '0;
      idx_next   = IDX_LAST;
      vote0_next = 1'b1;
      vote1_next = 1'b1;
    end else if (en) begin
      // The carry is the tick; the remainder stays in the accumulator so
      // the long-term rate carries no drift.
      acc_next  = sum[ACC_W-1:0];
      tick_next = carry;
      if (carry) begin
        idx_next = idx_inc;
        se_next  = (idx_inc == IDX_MID);
        bt_next  = (idx_inc == IDX_LAST);
        if (idx_inc == IDX_PRE) begin
          vote0_next = rx_in;
        end
        if (idx_inc == IDX_MID) begin
          vote1_next = rx_in;
        end
        if (idx_inc == IDX_POST) begin
          bv_next  = 1'b1;
          val_next = (vote0_reg & vote1_reg) | (vote0_reg & rx_in) | (vote1_reg & rx_in);
        end
      end
    end
  end

  // State register with synchronous reset to an idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg   <= '0;
      idx_reg   <= IDX_LAST;
      vote0_reg <= 1'b1;
      vote1_reg <= 1'b1;
      tick_reg  <= 1'b0;
      se_reg    <= 1'b0;
      bt_reg    <= 1'b0;
      bv_reg    <= 1'b0;
      val_reg   <= 1'b1;
    end else begin
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      vote0_reg <= vote0_next;
      vote1_reg <= vote1_next;
      tick_reg  <= tick_next;
      se_reg    <= se_next;
      bt_reg    <= bt_next;
      bv_reg    <= bv_next;
      val_reg   <= val_next;
    end
  end

  assign os_tick       = tick_reg;
  assign os_idx        = idx_reg;
  assign sample_enable = se_reg;
  assign bit_tick      = bt_reg;
  assign bit_valid     = bv_reg;
  assign bit_value     = val_reg;

endmodule
